// File: rtl/mips_pkg.sv
// Shared MIPS datapath types and constants, used by REGISTERS, MIPSALU and the
// ALU writeback buffer.
//   DATA_W      register / ALU data width
//   REG_ADDR_W  register-file address width
//   ZERO_REG    hardwired $zero register index
//   wb_entry_t  one pending register-file write {destination, data}
package mips_pkg;
  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] waddr;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;
endpackage

// File: rtl/alu_writeback_buffer_if.sv
// ALU-result capture and register-file write port bundle.
//   alu_valid/alu_ready              ALU -> buffer handshake
//   ALUOut/WriteRegIn/RegWriteIn     ALU result payload
//   RegWrite/WriteReg/WriteData      buffer -> register-file write request
//   wb_ready                         register file accepts the write
// slave: the buffer side; master: the ALU / register-file side.
interface alu_writeback_buffer_if;
  import mips_pkg::*;
  logic                  alu_valid;
  logic                  alu_ready;
  logic [DATA_W-1:0]     ALUOut;
  logic [REG_ADDR_W-1:0] WriteRegIn;
  logic                  RegWriteIn;
  logic                  RegWrite;
  logic [REG_ADDR_W-1:0] WriteReg;
  logic [DATA_W-1:0]     WriteData;
  logic                  wb_ready;

  modport slave (
    input  alu_valid, ALUOut, WriteRegIn, RegWriteIn, wb_ready,
    output alu_ready, RegWrite, WriteReg, WriteData
  );
  modport master (
    output alu_valid, ALUOut, WriteRegIn, RegWriteIn, wb_ready,
    input  alu_ready, RegWrite, WriteReg, WriteData
  );
endinterface

// File: rtl/wb_result_fifo.sv
// In-order DEPTH-entry FIFO of wb_entry_t.
//   clk/rst           clock, async active-high reset
//   push/push_data    enqueue (ignored when full)
//   pop               dequeue head (ignored when empty)
//   full/empty/count  occupancy status
//   head              oldest entry, zero when empty
//   rd_ptr            slot index of the head (oldest)
//   slots/slot_vld    raw storage and per-slot valid bits for forwarding scans
module wb_result_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  wb_entry_t             push_data,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [CW-1:0]         count,
  output wb_entry_t             head,
  output logic [PW-1:0]         rd_ptr,
  output wb_entry_t [DEPTH-1:0] slots,
  output logic [DEPTH-1:0]      slot_vld
);
  logic [PW-1:0]         wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
  logic [CW-1:0]         count_d, count_q;
  logic [DEPTH-1:0]      vld_d, vld_q;
  wb_entry_t [DEPTH-1:0] mem_d, mem_q;
  logic                  push_ok, pop_ok;

  // Status comes from the count so a full ring never aliases as empty.
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    vld_d    = vld_q;
    mem_d    = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      vld_d[wr_ptr_q] = 1'b1;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + 1'b1;
    end
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      vld_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      vld_q    <= vld_d;
    end
  end

  // Payload storage is left unreset; every consumer masks it with vld_q.
  always_ff @(posedge clk) mem_q <= mem_d;

  assign head     = vld_q[rd_ptr_q] ? mem_q[rd_ptr_q] : '0;
  assign count    = count_q;
  assign rd_ptr   = rd_ptr_q;
  assign slots    = mem_q;
  assign slot_vld = vld_q;
endmodule

// File: rtl/alu_writeback_buffer.sv
// Buffers MIPSALU results in order and drives the register-file write port,
// with combinational forwarding of not-yet-written results.
//   CLK/RESET             clock, async active-high reset
//   bus                   ALU handshake + register-file write port
//   ReadReg1/2            forwarding lookup addresses
//   fwd_hit1/2, data1/2   youngest buffered match per lookup (zero on miss)
//   occupancy             buffered entry count
//   retired               accepted instruction count (wraps)
module alu_writeback_buffer
  import mips_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter bit DROP_R0 = 1'b1,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  alu_writeback_buffer_if.slave bus,
  input  logic [REG_ADDR_W-1:0] ReadReg1,
  input  logic [REG_ADDR_W-1:0] ReadReg2,
  output logic                  fwd_hit1,
  output logic                  fwd_hit2,
  output logic [DATA_W-1:0]     fwd_data1,
  output logic [DATA_W-1:0]     fwd_data2,
  output logic [CW-1:0]         occupancy,
  output logic [31:0]           retired
);
  logic                             full, empty, accept, push, pop;
  logic [PW-1:0]                    rd_ptr, idx;
  wb_entry_t                        head, push_data;
  wb_entry_t [DEPTH-1:0]            slots;
  logic [DEPTH-1:0]                 slot_vld;
  logic [1:0][REG_ADDR_W-1:0]       rd_addr;
  logic [1:0]                       hit;
  logic [1:0][DATA_W-1:0]           fdata;
  logic [31:0]                      retired_d, retired_q;

  // alu_ready depends only on registered occupancy, never on wb_ready.
  assign bus.alu_ready = !full;
  assign accept        = bus.alu_valid && !full;
  assign push          = accept && bus.RegWriteIn &&
                         !(DROP_R0 && (bus.WriteRegIn == ZERO_REG));
  assign pop           = bus.wb_ready && !empty;
  assign push_data     = '{waddr: bus.WriteRegIn, data: bus.ALUOut};

  wb_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (CLK),
    .rst       (RESET),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .count     (occupancy),
    .head      (head),
    .rd_ptr    (rd_ptr),
    .slots     (slots),
    .slot_vld  (slot_vld)
  );

  assign bus.RegWrite  = !empty;
  assign bus.WriteReg  = head.waddr;
  assign bus.WriteData = head.data;

  assign rd_addr = {ReadReg2, ReadReg1};

  // Walk from the head (oldest) towards the write pointer so the last match,
  // the youngest, wins. The popping head stays visible until the edge.
  always_comb begin
    hit   = '0;
    fdata = '0;
    idx   = '0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < DEPTH; i++) begin
        idx = rd_ptr + PW'(i);
        if (slot_vld[idx] && (slots[idx].waddr == rd_addr[p])) begin
          hit[p]   = 1'b1;
          fdata[p] = slots[idx].data;
        end
      end
      if (DROP_R0 && (rd_addr[p] == ZERO_REG)) begin
        hit[p]   = 1'b0;
        fdata[p] = '0;
      end
    end
  end

  assign fwd_hit1  = hit[0];
  assign fwd_hit2  = hit[1];
  assign fwd_data1 = fdata[0];
  assign fwd_data2 = fdata[1];

  // Non-writing and dropped-R0 transfers still retire.
  always_comb retired_d = retired_q + 32'(accept);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) retired_q <= '0;
    else       retired_q <= retired_d;
  end

  assign retired = retired_q;
endmodule

// File: doc/alu_writeback_buffer.md
Name: alu_writeback_buffer

Overview:
- Sits directly downstream of MIPSALU; captures each ALU result with its destination register and drives the register-file write port (WriteData/WriteReg/RegWrite).
- Holds results in a small in-order FIFO so ALU issue is decoupled from register-file write availability.
- Exposes combinational forwarding lookups so register reads see results that have not yet been written.

Parameters:
- DEPTH, 4, number of buffered results; power of two, minimum 2.
- DROP_R0, 1, when 1 writes to register 0 are discarded (hardwired $zero); when 0 they are buffered like any other register.

Ports:
- CLK  input  1  single clock; all state updates on posedge.
- RESET  input  1  asynchronous, active-high reset.
- alu_valid  input  1  ALU presents a completed instruction this cycle.
- alu_ready  output  1  buffer can accept; alu_ready = !full.
- ALUOut  input  32  ALU result.
- WriteRegIn  input  5  destination register (IR bits 15:11).
- RegWriteIn  input  1  instruction writes a register.
- RegWrite  output  1  head entry valid; register-file write request.
- WriteReg  output  5  head entry destination.
- WriteData  output  32  head entry data.
- wb_ready  input  1  register file accepts the write this cycle.
- ReadReg1, ReadReg2  input  5 each  forwarding lookup addresses.
- fwd_hit1, fwd_hit2  output  1 each  a buffered entry targets that register.
- fwd_data1, fwd_data2  output  32 each  data of the youngest matching entry.
- occupancy  output  clog2(DEPTH)+1  current entry count.
- retired  output  32  count of accepted instructions.

Behaviour:
- Accept: the transfer occurs when alu_valid && alu_ready at posedge. Enqueue only if RegWriteIn=1 and not (DROP_R0=1 and WriteRegIn=0). Every accepted transfer increments retired, including non-enqueued transfers. retired wraps at 2^32-1 -> 0.
- Latency: an entry accepted at edge N is visible on RegWrite/WriteReg/WriteData after edge N. There is no same-cycle pass-through.
- Drain: a write completes when RegWrite && wb_ready at posedge. The head then pops and the next entry is presented after that edge.
- Outputs are held stable while RegWrite=1 and wb_ready=0.
- When empty: RegWrite=0, WriteReg=0, WriteData=0.
- Simultaneous enqueue and pop: occupancy unchanged, order preserved.
- Full: alu_ready=0 even if a pop occurs in the same cycle. This keeps alu_ready free of any combinational path from wb_ready.
- Enqueue while empty with no pop: occupancy goes 0 -> 1 and the entry becomes the head.
- Pointers: read/write pointers wrap modulo DEPTH. Full/empty are derived from occupancy, never from pointer equality alone.
- Forwarding (combinational, per port):
  - Scan all valid entries; hit if entry.reg == ReadRegX.
  - With multiple matches, data comes from the youngest (closest to the write pointer).
  - An entry being popped this cycle still counts as a hit until the edge.
  - With no match: hit=0, data=0.
  - With DROP_R0=1, a lookup of register 0 never hits.
- Reset (asynchronous, any time including mid-drain): all entries invalidated, pointers=0, occupancy=0, retired=0, RegWrite=0, WriteReg=0, WriteData=0, fwd_hit*=0. alu_ready=1 once reset deasserts.
- No X on any output after reset. Entry storage may be unreset but must be masked by the valid bits.

Decomposition:
- Shared package mips_pkg:
  - DATA_W=32, REG_ADDR_W=5, ZERO_REG=5'd0.
  - Typedef wb_entry_t {reg addr, data}.
  - Shared with REGISTERS/MIPSALU.
- Sub-module wb_result_fifo:
  - Generic DEPTH-entry FIFO of wb_entry_t with push/pop/full/empty/count.
  - Exposes its storage array and per-slot valid vector for the forwarding scan.
- Forwarding priority scan, R0 filtering and the retired counter live in alu_writeback_buffer.

Test Plan:
- Single write: reset, accept {reg 2, 0x7}, wb_ready=1 -> RegWrite=1, WriteReg=2, WriteData=0x7 on the next cycle; occupancy back to 0 after the following edge; retired=1.
- Back-pressure/full (DEPTH=4): wb_ready=0, offer 5 results to regs 1..5 -> first 4 accepted, alu_ready=0 at occupancy 4, fifth held. Raise wb_ready -> writes 1,2,3,4 drain in order and the fifth is accepted when alu_ready returns.
- Forwarding priority: buffer {reg 9, 0xd} then {reg 9, 0x3} with wb_ready=0, ReadReg1=9 -> fwd_hit1=1, fwd_data1=0x3. ReadReg2=10 -> fwd_hit2=0, fwd_data2=0.
- R0 and non-writing ops: accept {reg 0, 0x5, RegWriteIn=1} and {reg 4, 0x1, RegWriteIn=0} -> occupancy stays 0, RegWrite never asserts, retired=2. Repeat with DROP_R0=0 -> reg 0 write appears.
- Simultaneous push/pop: occupancy 2, wb_ready=1 and alu_valid=1 every cycle for 6 cycles -> occupancy stays 2, written data sequence matches the accepted sequence.
- Reset mid-operation: 3 entries buffered, assert RESET between edges -> RegWrite, fwd_hit*, occupancy and retired drop to 0 immediately. After release the first accepted entry is written with no stale data.
